// File: rtl/delay_sched_pkg.sv
// -----------------------------------------------------------------------------
// delay_sched_pkg
// Shared definitions for the delay line scheduler:
//   MAX_REQ     - largest supported requester count
//   tag_width   - requester tag width, max(1, clog2(n))
//   stage_width - packed width of one pipeline stage {valid, tag, data}
// -----------------------------------------------------------------------------
package delay_sched_pkg;

    localparam int MAX_REQ = 16;

    function automatic int tag_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int stage_width(input int tag_w, input int data_w);
        return 1 + tag_w + data_w;
    endfunction

endpackage

// File: rtl/delay_line_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and wraps
// upward modulo NUM_REQ; the first asserted request wins.
// Ports:
//   req    in  [NUM_REQ-1:0]  request vector
//   ptr    in  [TAG_W-1:0]    highest-priority index this cycle
//   grant  out [NUM_REQ-1:0]  one-hot grant, zero when no request
//   winner out [TAG_W-1:0]    index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
    import delay_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = tag_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   winner
);

    logic found;

    // Two passes give the wrap: first the indices at or above ptr, then the
    // full range from 0 (only reached if nothing at or above ptr requested).
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                winner   = TAG_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                winner   = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/delay_line_scheduler.sv
// -----------------------------------------------------------------------------
// delay_line_scheduler
// Shares one DELAY-stage pipelined delay line among NUM_REQ requesters through a
// round-robin arbiter. Each accepted word carries its requester index and
// emerges DELAY cycles after acceptance.
// Optional feature macro: DELAY_SCHED_STATS_EN (per-requester saturating grant
// counters on grant_count).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   req          in   [NUM_REQ]            per-requester request, held until granted
//   req_data     in   [NUM_REQ*DATA_WIDTH] requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   flush        in   synchronous pipeline clear, blocks grants
//   grant        out  [NUM_REQ]            combinational one-hot grant
//   out_valid    out  registered output valid
//   out_tag      out  [TAG_W]              requester index of out_data
//   out_data     out  [DATA_WIDTH]         delayed data word
//   busy         out  any stage holds a valid word
//   grant_count  out  [NUM_REQ*CNT_WIDTH]  grant counters (stats build only)
// -----------------------------------------------------------------------------
module delay_line_scheduler
    import delay_sched_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_REQ    = 4,
    parameter int  DELAY      = 1,
    parameter int  CNT_WIDTH  = 16,
    localparam int TAG_W      = tag_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          flush,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          out_valid,
    output logic [TAG_W-1:0]              out_tag,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy
`ifdef DELAY_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_count
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_q [DELAY];
    stage_t           stage_d [DELAY];
    logic [TAG_W-1:0] ptr_q, ptr_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [TAG_W-1:0]   arb_winner;
    logic               accept;
    logic [DATA_WIDTH-1:0] win_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    always_comb begin
        grant    = (rst || flush) ? '0 : arb_grant;
        accept   = |grant;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (arb_winner == TAG_W'(NUM_REQ - 1)) ? '0 : arb_winner + 1'b1;
        end

        // Bubbles are all-zero so the output fields read 0 whenever invalid.
        stage_d[0] = '0;
        if (accept) begin
            stage_d[0].valid = 1'b1;
            stage_d[0].tag   = arb_winner;
            stage_d[0].data  = win_data;
        end
        for (int k = 1; k < DELAY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (flush) begin
            for (int k = 0; k < DELAY; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int k = 0; k < DELAY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int k = 0; k < DELAY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DELAY; k++) begin
            busy = busy | stage_q[k].valid;
        end
    end

    assign out_valid = stage_q[DELAY-1].valid;
    assign out_tag   = stage_q[DELAY-1].tag;
    assign out_data  = stage_q[DELAY-1].data;

`ifdef DELAY_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_q [NUM_REQ];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_REQ];

    // grant is already zero under rst/flush, so flush leaves counts alone.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_delay_line_scheduler.sv
module tb_delay_line_scheduler;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            flush;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;

    logic [NR-1:0] a_grant, b_grant;
    logic          a_valid, b_valid;
    logic [1:0]    a_tag, b_tag;
    logic [DW-1:0] a_data, b_data;
    logic          a_busy, b_busy;
`ifdef DELAY_SCHED_STATS_EN
    logic [NR*CW-1:0] a_gc, b_gc;
`endif

    delay_line_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DELAY(1), .CNT_WIDTH(CW)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .flush(flush),
        .grant(a_grant), .out_valid(a_valid), .out_tag(a_tag), .out_data(a_data),
        .busy(a_busy)
`ifdef DELAY_SCHED_STATS_EN
        , .grant_count(a_gc)
`endif
    );

    delay_line_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DELAY(3), .CNT_WIDTH(CW)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .flush(flush),
        .grant(b_grant), .out_valid(b_valid), .out_tag(b_tag), .out_data(b_data),
        .busy(b_busy)
`ifdef DELAY_SCHED_STATS_EN
        , .grant_count(b_gc)
`endif
    );

    typedef struct {
        int side;
        int due;
        int tag;
        int data;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   edge_n = 0;
    int   ptr_m  = 0;
    int   cnt_m [NR];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] model_grant();
        logic [NR-1:0] g;
        int idx;
        g = '0;
        if (!(rst || flush)) begin
            for (int k = NR - 1; k >= 0; k--) begin
                idx = (ptr_m + k) % NR;
                if (req[idx]) g = NR'(1) << idx;
            end
        end
        return g;
    endfunction

    task automatic check_side(input int s, input string nm, input logic v, input logic [1:0] t,
                              input logic [DW-1:0] d, input logic b);
        int idx;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && q[i].side == s) idx = i;
        end
        chk({nm, "_busy"}, 32'(b), 32'(idx >= 0));
        if (idx >= 0 && q[idx].due == edge_n) begin
            chk({nm, "_valid"}, 32'(v), 32'd1);
            chk({nm, "_tag"},   32'(t), 32'(q[idx].tag));
            chk({nm, "_data"},  32'(d), 32'(q[idx].data));
            q.delete(idx);
        end else begin
            chk({nm, "_valid"}, 32'(v), 32'd0);
            chk({nm, "_tag"},   32'(t), 32'd0);
            chk({nm, "_data"},  32'(d), 32'd0);
        end
    endtask

    task automatic tick();
        logic [NR-1:0] g_exp;
        logic [DW-1:0] dv;
        int w;
`ifdef DELAY_SCHED_STATS_EN
        logic [NR*CW-1:0] gc_exp;
`endif
        #1;
        g_exp = model_grant();
        chk("grant_a", 32'(a_grant), 32'(g_exp));
        chk("grant_b", 32'(b_grant), 32'(g_exp));
        if (rst) begin
            q.delete();
            ptr_m = 0;
            for (int i = 0; i < NR; i++) cnt_m[i] = 0;
        end else if (flush) begin
            q.delete();
        end else if (g_exp != '0) begin
            w  = 0;
            dv = '0;
            for (int i = 0; i < NR; i++) begin
                if (g_exp[i]) begin
                    w  = i;
                    dv = req_data[i*DW +: DW];
                end
            end
            q.push_back('{0, edge_n + 1, w, int'(dv)});
            q.push_back('{1, edge_n + 3, w, int'(dv)});
            ptr_m = (w + 1) % NR;
            if (cnt_m[w] < (1 << CW) - 1) cnt_m[w]++;
        end
        @(posedge clk);
        edge_n++;
        #1;
        check_side(0, "a", a_valid, a_tag, a_data, a_busy);
        check_side(1, "b", b_valid, b_tag, b_data, b_busy);
`ifdef DELAY_SCHED_STATS_EN
        for (int i = 0; i < NR; i++) gc_exp[i*CW +: CW] = CW'(cnt_m[i]);
        chk("gcount_a", 32'(a_gc), 32'(gc_exp));
        chk("gcount_b", 32'(b_gc), 32'(gc_exp));
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int sat_seq [5];
        sat_seq = '{1, 2, 3, 3, 3};
        for (int i = 0; i < NR; i++) cnt_m[i] = 0;
        rst = 1'b1; flush = 1'b0; req = '0; req_data = '0;
        tick();
        req = 4'b1111;                      // grant must stay 0 while rst is high
        tick();
        rst = 1'b0; req = '0;
        tick();

        // 1: single word, DELAY=1 and DELAY=3
        req = 4'b0001; req_data = 32'h0000_0001;
        tick();
        chk("t1_valid", 32'(a_valid), 32'd1);
        chk("t1_data",  32'(a_data),  32'h01);
        req = '0;
        tick();
        chk("t1_after_data", 32'(a_data), 32'h00);
        ticks(2);

        // 2: all four requesters held continuously, after reset so ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; req_data = 32'hA3A2_A1A0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_tag",  32'(a_tag),  32'(k % 4));
            chk("t2_data", 32'(a_data), 32'(8'hA0 + (k % 4)));
        end
        req = '0;
        ticks(3);

        // 3: DELAY=3 latency and busy width; ptr is 1 here
        req = 4'b0100; req_data = 32'h0055_0000;
        tick();
        req = '0;
        busy_cnt = int'(b_busy);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) begin
                chk("t3_valid", 32'(b_valid), 32'd1);
                chk("t3_tag",   32'(b_tag),   32'd2);
                chk("t3_data",  32'(b_data),  32'h55);
            end
            busy_cnt += int'(b_busy);
        end
        chk("t3_busy_cycles", 32'(busy_cnt), 32'd3);

        // 4: fill DELAY=3 pipe (ptr 3 -> grants 3,0,1, ptr ends at 2), then flush
        req = 4'b1111; req_data = 32'hA3A2_A1A0;
        ticks(3);
        flush = 1'b1;
        #1 chk("t4_flush_grant", 32'(b_grant), 32'd0);
        tick();
        chk("t4_busy_after_flush", 32'(b_busy), 32'd0);
        flush = 1'b0;
        #1 chk("t4_grant_after_flush", 32'(b_grant), 32'b0100);
        tick();
        req = '0;
        ticks(3);

        // 5: rst mid-stream with ptr=2 and req=0100
        req = 4'b0010;
        tick();
        req = 4'b0100; rst = 1'b1;
        tick();
        chk("t5_valid", 32'(b_valid), 32'd0);
        chk("t5_busy",  32'(b_busy),  32'd0);
        rst = 1'b0; req = 4'b1111;
        #1 chk("t5_first_grant", 32'(a_grant), 32'b0001);
        tick();
        req = '0;
        ticks(3);

`ifdef DELAY_SCHED_STATS_EN
        // 6: saturating counters, CNT_WIDTH=2
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0001; req_data = 32'h0000_0077;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_count0", 32'(a_gc[CW-1:0]), 32'(sat_seq[k]));
            chk("t6_others", 32'(a_gc[NR*CW-1:CW]), 32'd0);
        end
        req = '0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_count_after_flush", 32'(a_gc[CW-1:0]), 32'd3);
        ticks(3);
`else
        sat_seq[0] = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/delay_line_scheduler.md
Name: delay_line_scheduler

Overview:
- Shares one pipelined delay line among NUM_REQ requesters using a round-robin arbiter.
- Each accepted word is tagged with its requester index and emerges exactly DELAY cycles later.
- Sits between multiple producers and a single delay resource; it handles grant sequencing, tag tracking and flush.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- NUM_REQ, 4, number of requesters; legal range 1..16.
- DELAY, 1, number of pipeline stages, i.e. acceptance-to-output latency in cycles; minimum 1.
- CNT_WIDTH, 16, width of the per-requester grant counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request; each bit held until granted
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- flush  in  1  synchronous pipeline clear
- grant  out  NUM_REQ  combinational one-hot grant
- out_valid  out  1  output word valid
- out_tag  out  TAG_W  index of the requester that supplied out_data
- out_data  out  DATA_WIDTH  delayed data word
- busy  out  1  high when any pipeline stage holds a valid word
- grant_count  out  NUM_REQ*CNT_WIDTH  per-requester grant counters (only with the optional feature)

Behaviour:
- Clocking: single clock domain, clk; rst is synchronous and active-high.
- Reset: all stages cleared (valid=0, tag=0, data=0); round-robin pointer ptr=0.
  - Resulting outputs: out_valid=0, out_tag=0, out_data=0, busy=0.
  - grant=0 while rst is high.
- Arbitration (combinational):
  - Search starts at index ptr and wraps upward modulo NUM_REQ.
  - The first i with req[i]=1 wins; grant is one-hot on that bit, or all zero if no requests.
- Acceptance: a word is accepted at the clk edge where req[i] & grant[i] = 1. The requester may drop req or change data after that edge.
- Pointer update: on acceptance of requester w, ptr <= (w+1) mod NUM_REQ. With no acceptance, ptr holds.
- Throughput: at most one acceptance per cycle.
- Pipeline: stage0 <= {accepted, tag=w, data=req_data[w]} on each edge, then stage k <= stage k-1.
  - A bubble stage carries valid=0, tag=0, data=0.
- Latency: a word accepted at edge t has out_valid=1 in the cycle following edge t+DELAY-1. With DELAY=1 it appears the cycle right after acceptance.
- Output drive:
  - out_valid, out_tag and out_data come directly from the last stage (registered).
  - When out_valid=0, out_tag=0 and out_data=0.
- busy: OR of all stage valid bits.
- Flush:
  - grant is forced to 0 in any cycle where flush=1, so no word is accepted.
  - At the edge, all stages are cleared; ptr is unchanged.
  - Words in flight are discarded without output.
- rst and flush together: rst dominates, so ptr=0.
- NUM_REQ=1: TAG_W=1; out_tag is always 0; grant = req & ~flush.
- TAG_W rule: max(1, $clog2(NUM_REQ)).

Optional Feature:
- Macro: DELAY_SCHED_STATS_EN.
- Defined:
  - grant_count holds one saturating counter per requester, reset to 0 by rst.
  - The counter increments on each acceptance from that requester and holds at 2^CNT_WIDTH-1.
  - flush does not clear the counters.
- Not defined: the grant_count port and all counter logic are absent.

Decomposition:
- Package delay_sched_pkg contains:
  - function tag_width(n) implementing max(1, $clog2(n));
  - a parameterized stage struct {valid, tag, data}, or an equivalent packed layout helper;
  - constant MAX_REQ=16.
- One sub-module, rr_arbiter:
  - Inputs: req, ptr.
  - Outputs: one-hot grant and winner index.
  - Purely combinational.
  - The pointer register stays in the parent.

Test Plan:
1. DELAY=1, NUM_REQ=4; req=0001, data0=8'h01 held for one cycle -> grant=0001; the next cycle out_valid=1, out_tag=0, out_data=8'h01; the cycle after, out_valid=0, out_data=8'h00.
2. All four requesters held continuously with data 8'hA0..8'hA3 -> grant sequence 0001, 0010, 0100, 1000, 0001; out_tag sequence 0,1,2,3,0 with matching data; no gaps.
3. DELAY=3; accept 8'h55 from requester 2 at edge t -> out_valid=1, out_tag=2, out_data=8'h55 in the cycle after edge t+2; busy=1 for exactly 3 cycles.
4. DELAY=3, pipeline full (three valid words); pulse flush for 1 cycle while req=1111 -> grant=0000 during the flush cycle, no output for the flushed words, busy=0 next cycle, and the next grant goes to the ptr index that was held before the flush.
5. Assert rst mid-stream with req=0100, ptr=2 -> the following cycle has out_valid=0 and busy=0; after rst drops with req=1111, the first grant is 0001.
6. With DELAY_SCHED_STATS_EN and CNT_WIDTH=2, hold req=0001 for 5 cycles -> grant_count[0] reads 1, 2, 3, 3, 3; all other counters stay 0; a flush leaves the counts unchanged.
